// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared constants and helpers for the pipelined multiplier.
//   MAX_INPUT_WIDTH : widest operand the multiplier accepts
//   MAX_LATENCY     : deepest pipeline the multiplier accepts
//   prod_width()    : width of the full-precision product for a given operand
//                     width
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int MAX_INPUT_WIDTH = 32;
    localparam int MAX_LATENCY     = 8;

    // A full-precision product of two w-bit operands needs 2*w bits.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage : mult_pkg

// File: rtl/mult_delay.sv
// -----------------------------------------------------------------------------
// mult_delay
// Enable-gated register chain of CYCLES stages, WIDTH bits wide. Every stage
// shifts on a rising clk edge when en_i is high and holds otherwise. The
// output is taken straight from the last register.
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears every stage
//   en_i  : advance enable
//   d_i   : data entering the first stage
//   q_o   : data leaving the last stage
// -----------------------------------------------------------------------------
module mult_delay #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [CYCLES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every stage is reset, not just the output, so that no
            // in-flight value survives a reset and re-emerges later.
            for (int i = 0; i < CYCLES; i++) begin
                stage_q[i] <= '0;
            end
        end else if (en_i) begin
            // NOTE: non-blocking assignments make all stages sample their
            // predecessor's old value, giving a true shift rather than a
            // single-cycle flow-through.
            stage_q[0] <= d_i;
            for (int i = 1; i < CYCLES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[CYCLES-1];

endmodule : mult_delay

// File: rtl/mult.sv
// -----------------------------------------------------------------------------
// mult
// Fully pipelined INPUT_WIDTH x INPUT_WIDTH multiplier producing a full
// 2*INPUT_WIDTH-bit product LATENCY enabled clock edges after the operands
// are sampled. Signed (two's-complement) or unsigned by IS_SIGNED.
//
// Optional feature: define MULT_VALID_EN to add a valid_in/valid_out
// side-band that travels through a register chain matching the data path.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset, clears all stages
//   en        : pipeline advance enable; all stages hold when low
//   in0, in1  : operands
//   valid_in  : (MULT_VALID_EN only) qualifies the operands
//   valid_out : (MULT_VALID_EN only) qualifies product
//   product   : registered full-precision product
// -----------------------------------------------------------------------------
module mult
    import mult_pkg::*;
#(
    parameter int INPUT_WIDTH = 8,
    parameter bit IS_SIGNED   = 1'b0,
    parameter int LATENCY     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [INPUT_WIDTH-1:0]     in0,
    input  logic [INPUT_WIDTH-1:0]     in1,
`ifdef MULT_VALID_EN
    input  logic                       valid_in,
    output logic                       valid_out,
`endif
    output logic [2*INPUT_WIDTH-1:0]   product
);

    localparam int PW = prod_width(INPUT_WIDTH);

    // Reject illegal configurations at elaboration time.
    if (INPUT_WIDTH < 1 || INPUT_WIDTH > MAX_INPUT_WIDTH) begin : g_bad_width
        $fatal(1, "mult: INPUT_WIDTH=%0d outside 1..%0d", INPUT_WIDTH, MAX_INPUT_WIDTH);
    end
    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $fatal(1, "mult: LATENCY=%0d outside 1..%0d", LATENCY, MAX_LATENCY);
    end

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] product_d;

    // Extending both operands to the product width first means the low PW
    // bits of an ordinary unsigned multiply are the exact result for both
    // signed and unsigned operands; nothing above bit PW-1 is ever needed.
    always_comb begin
        // NOTE: defaults are assigned before the conditional override so
        // every path drives every signal and no latch is inferred.
        a_ext = {{INPUT_WIDTH{1'b0}}, in0};
        b_ext = {{INPUT_WIDTH{1'b0}}, in1};
        if (IS_SIGNED) begin
            a_ext = {{INPUT_WIDTH{in0[INPUT_WIDTH-1]}}, in0};
            b_ext = {{INPUT_WIDTH{in1[INPUT_WIDTH-1]}}, in1};
        end
        product_d = a_ext * b_ext;
    end

    // The product is computed in front of the chain, so the first stage
    // already holds a finished result and product is purely registered.
    mult_delay #(
        .WIDTH  (PW),
        .CYCLES (LATENCY)
    ) u_data_delay (
        .clk  (clk),
        .rst  (rst),
        .en_i (en),
        .d_i  (product_d),
        .q_o  (product)
    );

`ifdef MULT_VALID_EN
    mult_delay #(
        .WIDTH  (1),
        .CYCLES (LATENCY)
    ) u_valid_delay (
        .clk  (clk),
        .rst  (rst),
        .en_i (en),
        .d_i  (valid_in),
        .q_o  (valid_out)
    );
`endif

endmodule : mult

// File: tb/tb_mult.sv
// -----------------------------------------------------------------------------
// tb_mult
// Three multiplier instances share one operand/enable/reset stream:
//   dut_u1 : W=8, unsigned, LATENCY=1
//   dut_s1 : W=8, signed,   LATENCY=1
//   dut_s3 : W=8, signed,   LATENCY=3
// A reference model keeps the most recent enabled operand samples since the
// last reset; each instance's product must be the arithmetic product of the
// sample taken LATENCY enabled edges ago, or 0 if there is none yet.
// -----------------------------------------------------------------------------
module tb_mult;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       vin;

    logic [15:0] prod_u1;
    logic [15:0] prod_s1;
    logic [15:0] prod_s3;
`ifdef MULT_VALID_EN
    logic        vout_u1;
    logic        vout_s1;
    logic        vout_s3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult #(.INPUT_WIDTH(8), .IS_SIGNED(1'b0), .LATENCY(1)) dut_u1 (
        .clk (clk), .rst (rst), .en (en), .in0 (in0), .in1 (in1),
`ifdef MULT_VALID_EN
        .valid_in (vin), .valid_out (vout_u1),
`endif
        .product (prod_u1)
    );

    mult #(.INPUT_WIDTH(8), .IS_SIGNED(1'b1), .LATENCY(1)) dut_s1 (
        .clk (clk), .rst (rst), .en (en), .in0 (in0), .in1 (in1),
`ifdef MULT_VALID_EN
        .valid_in (vin), .valid_out (vout_s1),
`endif
        .product (prod_s1)
    );

    mult #(.INPUT_WIDTH(8), .IS_SIGNED(1'b1), .LATENCY(3)) dut_s3 (
        .clk (clk), .rst (rst), .en (en), .in0 (in0), .in1 (in1),
`ifdef MULT_VALID_EN
        .valid_in (vin), .valid_out (vout_s3),
`endif
        .product (prod_s3)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       v;
    } smp_t;

    smp_t hist[$];

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                            input bit s);
        int ia;
        int ib;
        int p;
        if (s) begin
            ia = $signed(a);
            ib = $signed(b);
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        p = ia * ib;
        return p[15:0];
    endfunction

    function automatic logic [15:0] exp_p(input int lat, input bit s);
        if (hist.size() >= lat)
            return ref_mul(hist[hist.size()-lat].a, hist[hist.size()-lat].b, s);
        return 16'h0000;
    endfunction

    function automatic logic exp_v(input int lat);
        if (hist.size() >= lat)
            return hist[hist.size()-lat].v;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
        end else if (en) begin
            hist.push_back('{a: in0, b: in1, v: vin});
            if (hist.size() > 3) void'(hist.pop_front());
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_u1", prod_u1, exp_p(1, 1'b0));
        check("model_s1", prod_s1, exp_p(1, 1'b1));
        check("model_s3", prod_s3, exp_p(3, 1'b1));
`ifdef MULT_VALID_EN
        check("valid_u1", {15'd0, vout_u1}, {15'd0, exp_v(1)});
        check("valid_s1", {15'd0, vout_s1}, {15'd0, exp_v(1)});
        check("valid_s3", {15'd0, vout_s3}, {15'd0, exp_v(3)});
`endif
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic e);
        in0 = a;
        in1 = b;
        en  = e;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        vin = 1'b1;
        drive(8'h00, 8'h00, 1'b1);
        tick();
        tick();
        check("reset_u1", prod_u1, 16'h0000);
        check("reset_s3", prod_s3, 16'h0000);
        rst = 1'b0;

        // Extremes of the operand range, signed and unsigned.
        drive(8'hFF, 8'hFF, 1'b1); tick();
        check("ff_ff_u", prod_u1, 16'hFE01);
        check("ff_ff_s", prod_s1, 16'h0001);
        drive(8'h80, 8'h80, 1'b1); tick();
        check("80_80_u", prod_u1, 16'h4000);
        check("80_80_s", prod_s1, 16'h4000);
        drive(8'h80, 8'h7F, 1'b1); tick();
        check("80_7f_u", prod_u1, 16'h3F80);
        check("80_7f_s", prod_s1, 16'hC080);
        drive(8'hFF, 8'h01, 1'b1); tick();
        check("ff_01_u", prod_u1, 16'h00FF);
        check("ff_01_s", prod_s1, 16'hFFFF);

        // Back-to-back pairs through the 3-stage pipeline.
        drive(8'd2, 8'd3, 1'b1); tick();
        drive(8'd4, 8'd5, 1'b1); tick();
        drive(8'd6, 8'd7, 1'b1); tick();
        check("lat3_first", prod_s3, 16'd6);

        // Two stalled cycles: product holds, then the stream resumes in order.
        drive(8'd1, 8'd1, 1'b0); tick();
        check("stall_hold1", prod_s3, 16'd6);
        tick();
        check("stall_hold2", prod_s3, 16'd6);
        drive(8'd8, 8'd9, 1'b1); tick();
        check("resume_20", prod_s3, 16'd20);
        tick();
        check("resume_42", prod_s3, 16'd42);
        tick();
        check("resume_72", prod_s3, 16'd72);

        // Asynchronous reset between edges with results in flight.
        drive(8'd3, 8'd3, 1'b1); tick();
        drive(8'd5, 8'd5, 1'b1); tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_u1", prod_u1, 16'h0000);
        check("async_rst_s3", prod_s3, 16'h0000);
        tick();
        check("rst_hold_s3", prod_s3, 16'h0000);
        rst = 1'b0;
        drive(8'd10, 8'd10, 1'b1); tick();
        check("post_rst_u1", prod_u1, 16'd100);
        check("post_rst_s3a", prod_s3, 16'h0000);
        tick();
        check("post_rst_s3b", prod_s3, 16'h0000);
        tick();
        check("post_rst_s3c", prod_s3, 16'd100);

        // Random operands, enable and valid; the model process checks them.
        for (int i = 0; i < 1000; i++) begin
            vin = 1'($urandom);
            drive(8'($urandom), 8'($urandom), $urandom_range(0, 4) != 0);
            tick();
        end
        en = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mult
